// File: rtl/calendar_pkg.sv
// rtl/calendar_pkg.sv - shared month constants, month-length table and year bound
package calendar_pkg;

  localparam logic [3:0] JAN = 4'd1;
  localparam logic [3:0] FEB = 4'd2;
  localparam logic [3:0] MAR = 4'd3;
  localparam logic [3:0] APR = 4'd4;
  localparam logic [3:0] MAY = 4'd5;
  localparam logic [3:0] JUN = 4'd6;
  localparam logic [3:0] JUL = 4'd7;
  localparam logic [3:0] AUG = 4'd8;
  localparam logic [3:0] SEP = 4'd9;
  localparam logic [3:0] OCT = 4'd10;
  localparam logic [3:0] NOV = 4'd11;
  localparam logic [3:0] DEC = 4'd12;

  localparam logic [15:0] BCD_MAX_YEAR = 16'h9999;

  // Days per month indexed by binary month; February holds its non-leap length,
  // unused codes 0 and 13..15 read as 31 so the table is total.
  localparam logic [15:0][4:0] MLEN_TABLE = {
    5'd31, 5'd31, 5'd31, 5'd31,   // 15..12
    5'd30, 5'd31, 5'd30, 5'd31,   // 11..8
    5'd31, 5'd30, 5'd31, 5'd30,   // 7..4
    5'd31, 5'd28, 5'd31, 5'd31    // 3..0
  };

  // Length of a month; February gains the leap day when ly is set.
  function automatic logic [4:0] month_len(input logic [3:0] m, input logic ly);
    return MLEN_TABLE[m] + ((m == FEB) ? {4'd0, ly} : 5'd0);
  endfunction

endpackage

// File: rtl/bcd_year_incr.sv
// rtl/bcd_year_incr.sv - combinational four-digit BCD increment with carry-out
module bcd_year_incr (
  input  logic [15:0] i_year,
  output logic [15:0] o_year,
  output logic        o_carry
);

  logic [15:0] w_next;
  logic        w_c;

  // Ripple the +1 from the ones digit upward; a 9 wraps to 0 and passes the carry on.
  always_comb begin
    w_next = i_year;
    w_c    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_c) begin
        if (i_year[4*i +: 4] == 4'd9) begin
          w_next[4*i +: 4] = 4'd0;
        end else begin
          w_next[4*i +: 4] = i_year[4*i +: 4] + 4'd1;
          w_c              = 1'b0;
        end
      end
    end
    o_year  = w_next;
    o_carry = w_c;
  end

endmodule

// File: rtl/bcd_date_counter.sv
// rtl/bcd_date_counter.sv - BCD-year calendar date register advancing one day per tick
module bcd_date_counter
  import calendar_pkg::*;
#(
  parameter logic [15:0] RST_YEAR  = 16'h1582,
  parameter logic [3:0]  RST_MONTH = 4'd10,
  parameter logic [4:0]  RST_DAY   = 5'd15,
  parameter logic [15:0] MIN_YEAR  = 16'h1582
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        load,
  input  logic [15:0] ld_year,
  input  logic [3:0]  ld_month,
  input  logic [4:0]  ld_day,
  input  logic        LY,
  output logic [3:0]  YM,
  output logic [3:0]  YH,
  output logic [3:0]  YT,
  output logic [3:0]  YO,
  output logic [3:0]  month,
  output logic [4:0]  day,
  output logic        new_year,
  output logic        sat,
  output logic        load_err
);

  logic [15:0] r_year;
  logic [3:0]  r_month;
  logic [4:0]  r_day;
  logic        r_new_year;
  logic        r_load_err;

  logic [15:0] w_year_inc;
  logic        w_year_carry;
  logic [4:0]  w_mlen;
  logic [4:0]  w_ld_mlen;
  logic        w_ld_valid;
  logic        w_sat;

  logic [15:0] w_year_nxt;
  logic [3:0]  w_month_nxt;
  logic [4:0]  w_day_nxt;
  logic        w_new_year_nxt;
  logic        w_load_err_nxt;

  bcd_year_incr u_year_incr (
    .i_year  (r_year),
    .o_year  (w_year_inc),
    .o_carry (w_year_carry)
  );

  assign w_mlen    = month_len(r_month, LY);
  assign w_ld_mlen = month_len(ld_month, 1'b1);
  assign w_sat     = (r_year == BCD_MAX_YEAR) && (r_month == DEC) && (r_day == 5'd31);

  // Load check: BCD digits, lower year bound, month range, day against the leap-tolerant length.
  always_comb begin
    w_ld_valid = (ld_year[15:12] <= 4'd9) && (ld_year[11:8] <= 4'd9) &&
                 (ld_year[7:4]   <= 4'd9) && (ld_year[3:0]  <= 4'd9) &&
                 (ld_year >= MIN_YEAR) &&
                 (ld_month >= JAN) && (ld_month <= DEC) &&
                 (ld_day != 5'd0) && (ld_day <= w_ld_mlen);
  end

  // Next-state selection: load beats tick; a tick rolls day, then month, then year.
  always_comb begin
    w_year_nxt     = r_year;
    w_month_nxt    = r_month;
    w_day_nxt      = r_day;
    w_new_year_nxt = 1'b0;
    w_load_err_nxt = 1'b0;
    if (load) begin
      if (w_ld_valid) begin
        w_year_nxt  = ld_year;
        w_month_nxt = ld_month;
        w_day_nxt   = ld_day;
      end else begin
        w_load_err_nxt = 1'b1;
      end
    end else if (tick && !w_sat) begin
      if (r_day < w_mlen) begin
        w_day_nxt = r_day + 5'd1;
      end else if (r_month < DEC) begin
        w_day_nxt   = 5'd1;
        w_month_nxt = r_month + 4'd1;
      end else if (!w_year_carry) begin
        w_day_nxt      = 5'd1;
        w_month_nxt    = JAN;
        w_year_nxt     = w_year_inc;
        w_new_year_nxt = 1'b1;
      end
    end
  end

  // Date and pulse registers; reset forces the configured start date at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_year     <= RST_YEAR;
      r_month    <= RST_MONTH;
      r_day      <= RST_DAY;
      r_new_year <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_year     <= w_year_nxt;
      r_month    <= w_month_nxt;
      r_day      <= w_day_nxt;
      r_new_year <= w_new_year_nxt;
      r_load_err <= w_load_err_nxt;
    end
  end

  assign YM       = r_year[15:12];
  assign YH       = r_year[11:8];
  assign YT       = r_year[7:4];
  assign YO       = r_year[3:0];
  assign month    = r_month;
  assign day      = r_day;
  assign new_year = r_new_year;
  assign load_err = r_load_err;
  assign sat      = w_sat;

endmodule
